fifo_dual_pop: RTL
==================

Name: fifo_dual_pop

Overview:
- Single-push, dual-pop FIFO. It is the read-side counterpart of the dual-push FIFO.
- One producer writes at most one entry per cycle.
- The consumer sees the two oldest entries in parallel and may retire 0, 1 or 2 of them per cycle, in order.
- Sits between a single-issue producer (e.g. a fetch/decode queue) and a dual-issue consumer stage.

Parameters:
- FALL_THROUGH, 1'b1: empty/near-empty bypass of data_i to the read ports in the same cycle.
- DATA_WIDTH, 32: entry width when dtype is the default logic vector.
- DEPTH, 8: number of entries. Legal range is 2..2**16; the DEPTH < 2 check fires at elaboration.
- dtype, logic [DATA_WIDTH-1:0]: entry type.
- ADDR_DEPTH, $clog2(DEPTH): pointer width. Derived; never overridden.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- flush_i  in  1  synchronous clear of all entries
- testmode_i  in  1  bypasses clock gating in test mode
- full_o  out  1  count == DEPTH
- empty_o  out  1  no entry visible on port 0, fall-through included
- usage_o  out  ADDR_DEPTH+1  stored entry count, 0..DEPTH
- data_i  in  dtype  push data
- push_i  in  1  push request
- data_0_o  out  dtype  oldest visible entry
- valid_0_o  out  1  data_0_o is poppable
- data_1_o  out  dtype  second-oldest visible entry
- valid_1_o  out  1  data_1_o is poppable
- pop_0_i  in  1  retire entry on port 0
- pop_1_i  in  1  retire entry on port 1; only legal together with pop_0_i

Behaviour:
- State: mem_q[DEPTH], rd_ptr_q, wr_ptr_q (ADDR_DEPTH bits), cnt_q (ADDR_DEPTH+1 bits).
- Reset and flush values:
  - All registers are cleared by reset; mem_q is cleared to '0.
  - Output values out of reset: full_o=0, empty_o=1, usage_o=0, valid_0_o=0, valid_1_o=0, data_0_o=data_1_o='0 while push_i is low.
- flush_i (synchronous):
  - Next state is pointers=0, cnt=0, mem=0.
  - Overrides any push or pop in the same cycle; pop_*_i is ignored, and outputs in that cycle are still computed normally.
- Push:
  - Accepted iff push_i && !full_o. full_o depends only on cnt_q, so a push into a full FIFO is dropped even if a pop occurs in the same cycle.
  - An accepted push writes mem[wr_ptr] unless it is consumed by fall-through.
  - wr_ptr increments; when it reaches DEPTH-1 the next value is 0 (non-power-of-2 DEPTH supported).
  - mem update is clock-gated by "no write" unless testmode_i=1.
- Read view, non-fall-through or cnt_q >= 2:
  - data_0_o = mem[rd_ptr], data_1_o = mem[rd_ptr+1 mod DEPTH].
  - valid_0_o = cnt_q >= 1, valid_1_o = cnt_q >= 2.
- Fall-through (FALL_THROUGH=1):
  - cnt_q == 0 && push_i: data_0_o = data_i, valid_0_o = 1.
  - cnt_q == 1 && push_i: data_1_o = data_i, valid_1_o = 1.
  - A bypassed entry that is popped in the same cycle is never written to mem and does not increment cnt.
- empty_o = !valid_0_o.
- Pop:
  - Number of entries retired: n_pop = (pop_0_i && valid_0_o) + (pop_0_i && pop_1_i && valid_1_o).
  - rd_ptr advances by n_pop modulo DEPTH; wrap is handled for +2 crossing the end (DEPTH-1 -> 1, DEPTH-2 -> 0).
- Count: cnt_n = cnt_q + push_accepted - n_pop, always in 0..DEPTH.
- Simultaneous events:
  - Push and two pops at cnt_q=2: cnt_n=1, and the new entry is written at wr_ptr.
  - Push and pop_0 at cnt_q=0 under fall-through: cnt_n=0, pointers unchanged.
- Illegal requests:
  - pop_1_i without pop_0_i is ignored (no state change from port 1).
  - Simulation asserts, SYNTHESIS/COMMON_CELLS_ASSERTS_OFF guarded, are fatal on:
    - push when full,
    - pop_0 with !valid_0,
    - pop_1 with !valid_1,
    - pop_1 without pop_0.
- Latency:
  - Non-fall-through: a pushed entry is visible on port 0 the cycle after push.
  - Fall-through: visible in the same cycle.

Decomposition:
- No shared package needed. Add a local function for modulo-DEPTH pointer increment (by 1 or 2) in the module.
- No sub-module: storage is a flop array; the same pointer arithmetic as the existing dual-push FIFO is reused via the local function.

Test Plan:
1. Reset, then push 0xA1,0xA2,0xA3 on consecutive cycles with FALL_THROUGH=0 -> after the third push, usage_o=3, data_0_o=0xA1, data_1_o=0xA2, both valids set.
2. From state 1, pop_0_i=pop_1_i=1 for one cycle -> usage_o=1, data_0_o=0xA3, valid_1_o=0. Then a same-cycle dual pop retires only 1 and fires the assertion; a separate pop_1-only attempt is ignored.
3. DEPTH=5: fill 5 entries (full_o=1), then pop 2/cycle while pushing until wr_ptr and rd_ptr each wrap twice -> output order matches the push order exactly, including the rd_ptr 4->1 wrap. A push when full is dropped with usage_o unchanged at 5.
4. FALL_THROUGH=1, empty, push 0x55 with pop_0_i=1 -> data_0_o=0x55 and valid_0_o=1 in the same cycle, next cycle usage_o=0, empty_o=1.
5. FALL_THROUGH=1, cnt=1 (0x11), push 0x22 with pop_0_i=pop_1_i=1 -> both 0x11 and 0x22 retire, next usage_o=0.
6. 4 entries stored, assert flush_i together with push_i and pop_0_i -> next cycle usage_o=0, empty_o=1, valid_0_o=0. Asserting rst_ni low mid-burst gives the reset values immediately, asynchronously.

Source files
------------

// File: rtl/fifo_dual_pop.sv
// Single-push, dual-pop FIFO: one write per cycle, the consumer sees the two
// oldest entries and may retire 0, 1 or 2 of them in order each cycle.
module fifo_dual_pop #(
  parameter bit          FALL_THROUGH = 1'b1,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                testmode_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [ADDR_DEPTH:0] usage_o,
  input  dtype                data_i,
  input  logic                push_i,
  output dtype                data_0_o,
  output logic                valid_0_o,
  output dtype                data_1_o,
  output logic                valid_1_o,
  input  logic                pop_0_i,
  input  logic                pop_1_i
);

  if (DEPTH < 2) begin : g_depth_check
    $fatal(1, "fifo_dual_pop: DEPTH must be at least 2");
  end

  localparam logic [ADDR_DEPTH:0] DEPTH_C = (ADDR_DEPTH+1)'(DEPTH);
  localparam logic [ADDR_DEPTH:0] ONE_C   = (ADDR_DEPTH+1)'(1);
  localparam logic [ADDR_DEPTH:0] TWO_C   = (ADDR_DEPTH+1)'(2);

  // Modulo-DEPTH pointer advance by 0, 1 or 2; works for non-power-of-2 DEPTH.
  function automatic logic [ADDR_DEPTH-1:0] ptr_add(input logic [ADDR_DEPTH-1:0] ptr,
                                                    input logic [1:0] step);
    logic [ADDR_DEPTH:0] sum;
    sum = (ADDR_DEPTH+1)'(ptr) + (ADDR_DEPTH+1)'(step);
    if (sum >= DEPTH_C) sum = sum - DEPTH_C;
    return sum[ADDR_DEPTH-1:0];
  endfunction

  dtype                  mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [ADDR_DEPTH:0]   cnt_q, cnt_n;

  logic       push_acc, ft_0, ft_1, pop_0_ok, pop_1_ok, bypass_pop, write_en, mem_en;
  logic [1:0] n_pop, rd_step;

  always_comb begin
    full_o     = (cnt_q == DEPTH_C);
    push_acc   = push_i && !full_o;
    ft_0       = FALL_THROUGH && push_i && (cnt_q == '0);
    ft_1       = FALL_THROUGH && push_i && (cnt_q == ONE_C);
    data_0_o   = ft_0 ? data_i : mem_q[rd_ptr_q];
    data_1_o   = ft_1 ? data_i : mem_q[ptr_add(rd_ptr_q, 2'd1)];
    valid_0_o  = (cnt_q != '0) || ft_0;
    valid_1_o  = (cnt_q >= TWO_C) || ft_1;
    empty_o    = !valid_0_o;
    usage_o    = cnt_q;
    pop_0_ok   = pop_0_i && valid_0_o;
    pop_1_ok   = pop_0_i && pop_1_i && valid_1_o;
    n_pop      = {1'b0, pop_0_ok} + {1'b0, pop_1_ok};
    // A bypassed entry retired in the same cycle never touches storage.
    bypass_pop = (ft_0 && pop_0_ok) || (ft_1 && pop_1_ok);
    write_en   = push_acc && !bypass_pop;
    rd_step    = n_pop - {1'b0, bypass_pop};
    cnt_n      = cnt_q + (ADDR_DEPTH+1)'(push_acc) - (ADDR_DEPTH+1)'(n_pop);
    mem_en     = write_en || flush_i || testmode_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= ptr_add(rd_ptr_q, rd_step);
      if (write_en) wr_ptr_q <= ptr_add(wr_ptr_q, 2'd1);
      cnt_q    <= cnt_n;
    end
  end

  // Storage only clocks on a write or flush; test mode keeps the clock free-running.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else if (mem_en) begin
      if (flush_i) mem_q <= '{default: '0};
      else if (write_en) mem_q[wr_ptr_q] <= data_i;
    end
  end

`ifndef SYNTHESIS
`ifndef COMMON_CELLS_ASSERTS_OFF
  push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o))
    else $fatal(1, "fifo_dual_pop: push while full");
  pop_0_invalid: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_0_i && !valid_0_o))
    else $fatal(1, "fifo_dual_pop: pop_0 without valid_0");
  pop_1_invalid: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_1_i && !valid_1_o))
    else $fatal(1, "fifo_dual_pop: pop_1 without valid_1");
  pop_1_alone: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_1_i && !pop_0_i))
    else $fatal(1, "fifo_dual_pop: pop_1 without pop_0");
`endif
`endif

endmodule
